// File: rtl/kbd_pkg.sv
// Shared encodings for the PS/2 keyboard decoder: output state codes,
// special scan codes, decode FSM states and the scan-code-to-ASCII map.
`timescale 1ns/1ps
package kbd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PRESS = 2'b01;
  localparam logic [1:0] ST_HELD  = 2'b10;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_BRK     = 2'd1,
    FSM_EXT     = 2'd2,
    FSM_EXT_BRK = 2'd3
  } dec_fsm_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] ascii;
  } key_map_t;

  // Scan code to ASCII; letters go upper case when 'upper' is set.
  function automatic key_map_t scan_to_ascii(input logic [7:0] code, input logic upper);
    key_map_t   m;
    logic [7:0] lc;
    m  = '0;
    lc = 8'h00;
    case (code)
      8'h1C: lc = 8'h61; 8'h32: lc = 8'h62; 8'h21: lc = 8'h63; 8'h23: lc = 8'h64;
      8'h24: lc = 8'h65; 8'h2B: lc = 8'h66; 8'h34: lc = 8'h67; 8'h33: lc = 8'h68;
      8'h43: lc = 8'h69; 8'h3B: lc = 8'h6A; 8'h42: lc = 8'h6B; 8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D; 8'h31: lc = 8'h6E; 8'h44: lc = 8'h6F; 8'h4D: lc = 8'h70;
      8'h15: lc = 8'h71; 8'h2D: lc = 8'h72; 8'h1B: lc = 8'h73; 8'h2C: lc = 8'h74;
      8'h3C: lc = 8'h75; 8'h2A: lc = 8'h76; 8'h1D: lc = 8'h77; 8'h22: lc = 8'h78;
      8'h35: lc = 8'h79; 8'h1A: lc = 8'h7A;
      default: lc = 8'h00;
    endcase
    if (lc != 8'h00) begin
      m.valid = 1'b1;
      m.ascii = upper ? (lc - 8'h20) : lc;
    end else begin
      case (code)
        8'h45: m = {1'b1, 8'h30};
        8'h16: m = {1'b1, 8'h31};
        8'h1E: m = {1'b1, 8'h32};
        8'h26: m = {1'b1, 8'h33};
        8'h25: m = {1'b1, 8'h34};
        8'h2E: m = {1'b1, 8'h35};
        8'h36: m = {1'b1, 8'h36};
        8'h3D: m = {1'b1, 8'h37};
        8'h3E: m = {1'b1, 8'h38};
        8'h46: m = {1'b1, 8'h39};
        8'h29: m = {1'b1, 8'h20};
        8'h5A: m = {1'b1, 8'h0D};
        8'h66: m = {1'b1, 8'h08};
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 serial frame receiver: input synchronisers, falling-edge detect,
// 11-bit frame capture with start/parity/stop checks and a mid-frame timeout.
`timescale 1ns/1ps
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]      r_clk_sync;
  logic [1:0]      r_data_sync;
  logic [3:0]      r_bit_cnt;
  logic [9:0]      r_shift;
  logic [TO_W-1:0] r_idle_cnt;

  logic w_fall;
  logic w_sample;
  logic w_frame_ok;

  assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_sample   = r_data_sync[1];
  // r_shift[0] = start, [8:1] = data, [9] = parity; w_sample is the stop bit.
  assign w_frame_ok = ~r_shift[0] & (^r_shift[9:1]) & w_sample;

  // Two-flop synchronisers; clock gets a third stage for edge detection.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
    end
  end

  // Frame shift, validation on the stop edge, and idle timeout.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_bit_cnt    <= 4'd0;
      r_shift      <= '0;
      r_idle_cnt   <= '0;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (w_fall) begin
        r_idle_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          if (w_frame_ok) begin
            o_byte       <= r_shift[8:1];
            o_byte_valid <= 1'b1;
          end else begin
            o_frame_err  <= 1'b1;
          end
        end else begin
          r_shift   <= {w_sample, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt  <= 4'd0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder top: make/break/extended FSM, shift and caps-lock
// tracking, ASCII mapping and a stretched new-press pulse on 'state'.
// Build option: define KBD_TYPEMATIC_EN to make typematic repeats of the
// held key re-issue a full press pulse.
`timescale 1ns/1ps
module ps2_kbd_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned PULSE_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbd_ascii,
  output logic [1:0] state,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int unsigned PW = $clog2(PULSE_LEN + 1);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  dec_fsm_e   r_fsm,   w_fsm_nxt;
  logic       r_shift, w_shift_nxt;
  logic       r_caps,  w_caps_nxt;
  logic [7:0] r_held,  w_held_nxt;
  logic [7:0] r_ascii, w_ascii_nxt;
  logic [1:0] r_state, w_state_nxt;
  logic [PW-1:0] r_pcnt, w_pcnt_nxt;
  logic [7:0] r_scan,  w_scan_nxt;
  key_map_t   w_map;
  logic       w_issue;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .clrn         (clrn),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  // Decode FSM next state plus modifier, held-key and pulse bookkeeping.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_shift_nxt = r_shift;
    w_caps_nxt  = r_caps;
    w_held_nxt  = r_held;
    w_ascii_nxt = r_ascii;
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_scan_nxt  = r_scan;
    w_map       = scan_to_ascii(w_byte, r_shift ^ r_caps);
`ifdef KBD_TYPEMATIC_EN
    w_issue     = w_map.valid;
`else
    w_issue     = w_map.valid && (w_byte != r_held);
`endif

    if (r_state == ST_PRESS) begin
      if (r_pcnt == '0) w_state_nxt = ST_HELD;
      else              w_pcnt_nxt  = r_pcnt - PW'(1);
    end

    if (w_byte_valid) begin
      w_scan_nxt = w_byte;
      case (r_fsm)
        FSM_IDLE: begin
          if (w_byte == SC_BREAK) begin
            w_fsm_nxt = FSM_BRK;
          end else if (w_byte == SC_EXT) begin
            w_fsm_nxt = FSM_EXT;
          end else if (w_byte == SC_LSHIFT || w_byte == SC_RSHIFT) begin
            w_shift_nxt = 1'b1;
          end else if (w_byte == SC_CAPS) begin
            // Held caps code absorbs typematic repeats so caps toggles once.
            if (r_held != SC_CAPS) begin
              w_caps_nxt = ~r_caps;
              w_held_nxt = SC_CAPS;
            end
          end else if (w_issue) begin
            w_ascii_nxt = w_map.ascii;
            w_held_nxt  = w_byte;
            w_state_nxt = ST_PRESS;
            w_pcnt_nxt  = PW'(PULSE_LEN - 1);
          end
        end
        FSM_BRK: begin
          w_fsm_nxt = FSM_IDLE;
          if (w_byte == SC_LSHIFT || w_byte == SC_RSHIFT) begin
            w_shift_nxt = 1'b0;
          end else if (r_held != 8'h00 && w_byte == r_held) begin
            w_state_nxt = ST_IDLE;
            w_held_nxt  = 8'h00;
          end
        end
        FSM_EXT:     w_fsm_nxt = (w_byte == SC_BREAK) ? FSM_EXT_BRK : FSM_IDLE;
        FSM_EXT_BRK: w_fsm_nxt = FSM_IDLE;
        default:     w_fsm_nxt = FSM_IDLE;
      endcase
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_fsm   <= FSM_IDLE;
      r_shift <= 1'b0;
      r_caps  <= 1'b0;
      r_held  <= 8'h00;
      r_ascii <= 8'h00;
      r_state <= ST_IDLE;
      r_pcnt  <= '0;
      r_scan  <= 8'h00;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_shift <= w_shift_nxt;
      r_caps  <= w_caps_nxt;
      r_held  <= w_held_nxt;
      r_ascii <= w_ascii_nxt;
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_scan  <= w_scan_nxt;
    end
  end

  assign kbd_ascii = r_ascii;
  assign state     = r_state;
  assign scan_code = r_scan;
  assign frame_err = w_frame_err;

endmodule

// File: doc/ps2_kbd_decoder.md
Name: ps2_kbd_decoder

Overview:
- Upstream stage of the falling-character game core; turns a raw PS/2 keyboard stream into `kbd_ascii` plus a 2-bit `state` code.
- The game core latches a keystroke whenever `state==2'b01`.
- Contains a serial frame receiver, a make/break/extended decode FSM, shift and caps-lock tracking, and a scan-code-to-ASCII map.
- Runs on the 50 MHz system clock; the pulse is stretched so the 25 MHz consumer clock always samples it.

Parameters:
- PULSE_LEN, 4: clk cycles for which `state` is held at 2'b01 per accepted keystroke (≥2 required).
- TIMEOUT_CYCLES, 50000: idle clk cycles mid-frame before the receiver discards the partial frame (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw keyboard clock (asynchronous)
- ps2_data  in  1  raw keyboard data (asynchronous)
- kbd_ascii  out  8  ASCII of last accepted key
- state  out  2  00 idle, 01 new press, 10 key held, 11 unused
- scan_code  out  8  last valid received byte
- frame_err  out  1  one-cycle pulse on a bad frame

Behaviour:
- Reset values: while clrn=0 all outputs are 0; receiver, FSM, shift and caps flags are cleared.
- Input sync: ps2_clk and ps2_data each pass through 2 FFs. A falling edge is detected from the 3rd stage of ps2_clk.
- Frame receive: 11 bits shifted LSB-first on falling edges: start(0), 8 data bits, odd parity, stop(1).
  - Valid frame: the byte is presented to the decoder 1 cycle after the stop edge, and scan_code is updated.
  - Bad start, parity or stop: frame_err pulses for 1 cycle and the byte is discarded.
  - No edge for TIMEOUT_CYCLES while the bit counter is non-zero: the counter resets silently, with no frame_err.
- Decode FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: byte F0 goes to BRK. Byte E0 goes to EXT. Any other byte is a make and stays in IDLE.
  - BRK: the next byte is a break; return to IDLE.
  - EXT: F0 goes to EXT_BRK. Any other byte is swallowed; return to IDLE.
  - EXT_BRK: swallow one byte; return to IDLE.
  - Extended keys never affect outputs.
- Make handling:
  - 12 or 59 (shift): shift=1.
  - 58 (caps lock): caps toggles only if 58 is not already the held code.
  - Mapped key different from held_code: kbd_ascii <= map; held_code <= code; state <= 01 for PULSE_LEN cycles, then 10.
  - Mapped key equal to held_code (typematic repeat): no change.
  - Unmapped key: ignored.
- Break handling:
  - Shift break: shift=0.
  - Break of held_code: state <= 00; held_code <= 0; kbd_ascii keeps its value.
  - Break of any other key: ignored.
- Map:
  - Letters: 1C=a, 32=b, 21=c, 23=d, 24=e, 2B=f, 34=g, 33=h, 43=i, 3B=j, 42=k, 4B=l, 3A=m, 31=n, 44=o, 4D=p, 15=q, 2D=r, 1B=s, 2C=t, 3C=u, 2A=v, 1D=w, 22=x, 35=y, 1A=z. Uppercase (subtract 8'h20) when shift XOR caps.
  - Digits: 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'. Shift is ignored for digits.
  - Others: 29 = space 8'h20, 5A = 8'h0D, 66 = 8'h08.
- New press during a pulse: the pulse counter restarts; state stays 01 for a fresh PULSE_LEN cycles.
- Reset mid-frame or mid-pulse: everything is cleared immediately (asynchronous).

Optional Feature:
- Macro: KBD_TYPEMATIC_EN.
- Defined: a repeat make of held_code re-issues a full 01 pulse (autorepeat typing).
- Undefined: repeats are ignored as above.

Decomposition:
- Package kbd_pkg holds:
  - state encodings ST_IDLE/ST_PRESS/ST_HELD;
  - codes SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT, SC_RSHIFT, SC_CAPS;
  - the FSM state enum.
- Sub-module ps2_rx holds the synchronisers, edge detect, frame shift register, parity check and timeout. It outputs byte, byte_valid and frame_err.

Test Plan:
- Frames 1C, F0 1C → state=01 for exactly 4 cycles with kbd_ascii=8'h61, then 10; after the break, state=00 and kbd_ascii stays 8'h61.
- Frames 12, 1C → kbd_ascii=8'h41. Then 58 58 (caps toggled) with shift held, then 1C → 8'h61.
- Frame 1C with wrong parity → frame_err pulses once; state stays 00 and scan_code is unchanged.
- Frame 1C, then 1C repeated ×3 → exactly one 01 pulse; with KBD_TYPEMATIC_EN defined, four pulses.
- Frames E0 75, E0 F0 75 → no output change. Then 5 data bits followed by a 60000-cycle gap, then a full 32 frame → kbd_ascii=8'h62.
- clrn asserted mid-pulse → state=00, kbd_ascii=00 on the same cycle. After release, frame 45 → kbd_ascii=8'h30.
